// File: rtl/zle_pkg.sv
// Zero run-length codec: token-field constants and FSM encodings
// shared by the zle encoder and the zld decoder.
package zle_pkg;

  localparam int unsigned ZLE_DW    = 3;
  localparam int unsigned ZLE_FLAG  = ZLE_DW;
  localparam int unsigned ZLE_RUN_W = ZLE_DW;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_RUN   = 1'b1
  } zle_state_e;

endpackage

// File: rtl/zld_xc_fsm.sv
// Zero run-length decoder control: token acceptance, run counter,
// back-pressure and output-register load enables.
module zld_xc_fsm
  import zle_pkg::*;
#(
  parameter int unsigned DW = ZLE_DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          run_i,
  input  logic [DW-1:0] len_i,
  input  logic          valid_i,
  input  logic          free_i,
  output logic          busy_o,
  output logic          ld_o,
  output logic          lit_o,
  output logic          clr_o
);

  zle_state_e    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          acc;

  assign busy_o = (state_q == S_RUN) | ~free_i;
  assign acc    = valid_i & ~busy_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_o    = 1'b0;
    lit_o   = 1'b0;
    clr_o   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (acc) begin
          ld_o  = 1'b1;
          lit_o = ~run_i;
          // a length field of 0 is a single zero: no owed zeros left
          if (run_i && len_i != '0) begin
            cnt_d   = len_i;
            state_d = S_RUN;
          end
        end else if (free_i) begin
          clr_o = 1'b1;
        end
      end
      S_RUN: begin
        if (free_i) begin
          ld_o  = 1'b1;
          cnt_d = cnt_q - DW'(1);
          if (cnt_q == DW'(1)) begin
            state_d = S_FETCH;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/zld_xc.sv
// Zero run-length decoder: expands literal / zero-run tokens into
// one DW-bit sample per cycle behind a registered output stage.
module zld_xc
  import zle_pkg::*;
#(
  parameter int unsigned DW = ZLE_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW:0]   i_d,
  input  logic          i_v,
  output logic          i_b,
  output logic [DW-1:0] o_d,
  output logic          o_v,
  input  logic          o_b
);

  logic [DW-1:0] o_d_q;
  logic          o_v_q;
  logic          free;
  logic          ld;
  logic          lit;
  logic          clr;

  assign free = ~o_v_q | ~o_b;
  assign o_d  = o_d_q;
  assign o_v  = o_v_q;

  zld_xc_fsm #(
    .DW(DW)
  ) u_fsm (
    .clk_i  (clock),
    .rst_ni (reset),
    .run_i  (i_d[DW]),
    .len_i  (i_d[DW-1:0]),
    .valid_i(i_v),
    .free_i (free),
    .busy_o (i_b),
    .ld_o   (ld),
    .lit_o  (lit),
    .clr_o  (clr)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      o_v_q <= 1'b0;
      o_d_q <= '0;
    end else if (ld) begin
      o_v_q <= 1'b1;
      o_d_q <= lit ? i_d[DW-1:0] : '0;
    end else if (clr) begin
      o_v_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zld_xc.sv
// Scoreboard bench for zld_xc: directed token cases plus a random
// encoder-to-decoder loopback.
module tb_zld_xc;

  typedef logic [2:0] sq_t[$];

  logic       clk;
  logic       reset;
  logic [3:0] i_d;
  logic       i_v;
  logic       i_b;
  logic [2:0] o_d;
  logic       o_v;
  logic       o_b;

  int n_cmp;
  int n_bad;
  int cyc;
  int acc_cyc;
  int ib_hi;
  int nz;
  int ob_mode;
  int oc[$];
  logic [2:0] sb[$];
  logic       hold_v;
  logic [2:0] hold_d;

  zld_xc #(.DW(3)) dut (
    .clock(clk),
    .reset(reset),
    .i_d  (i_d),
    .i_v  (i_v),
    .i_b  (i_b),
    .o_d  (o_d),
    .o_v  (o_v),
    .o_b  (o_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic sq_t expand(input logic [3:0] t);
    sq_t q;
    logic [2:0] v;
    v = t[2:0];
    if (t[3]) begin
      for (int k = 0; k <= int'(v); k++) q.push_back(3'd0);
    end else begin
      q.push_back(v);
    end
    return q;
  endfunction

  // Monitor: pops the scoreboard on every consumed sample
  initial begin
    logic [2:0] e;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (i_b) ib_hi++;
      if (hold_v && o_v) check("hold_stable", int'(o_d), int'(hold_d));
      if (o_v && !o_b) begin
        oc.push_back(cyc);
        if (o_d == 3'd0) nz++;
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("data", int'(o_d), int'(e));
        end
      end
      hold_v = o_v && o_b && reset;
      hold_d = o_d;
    end
  end

  initial begin
    o_b = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ob_mode)
        1:       o_b = ~o_b;
        2:       o_b = 1'($urandom_range(0, 1));
        default: o_b = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [3:0] t, input sq_t smp);
    bit acc;
    acc = 1'b0;
    i_d = t;
    i_v = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = !i_b;
      acc_cyc = cyc;
      @(posedge clk);
      if (acc) break;
    end
    if (acc) begin
      foreach (smp[j]) sb.push_back(smp[j]);
    end else begin
      check("accept_timeout", 0, 1);
    end
    #1;
    i_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic consecutive(input string name, input int n);
    check({name, "_count"}, oc.size(), n);
    for (int k = 1; k < oc.size(); k++) begin
      check({name, "_consec"}, oc[k], oc[k-1] + 1);
    end
  endtask

  initial begin
    int a0;
    int base;
    int nd;
    int i;
    int len;
    logic [2:0] data[$];
    sq_t chunk;
    logic [3:0] tok;

    n_cmp = 0;
    n_bad = 0;
    ib_hi = 0;
    nz = 0;
    ob_mode = 0;
    reset = 1'b0;
    i_d = '0;
    i_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_o_v", int'(o_v), 0);
    check("rst_o_d", int'(o_d), 0);
    check("rst_i_b", int'(i_b), 0);
    @(posedge clk);
    #1;

    // literals 3,5,7 back-to-back
    oc.delete();
    ib_hi = 0;
    send(4'd3, expand(4'd3));
    a0 = acc_cyc;
    send(4'd5, expand(4'd5));
    send(4'd7, expand(4'd7));
    idle(3);
    consecutive("lit", 3);
    if (oc.size() > 0) check("lit_latency", oc[0], a0 + 1);
    check("lit_ib", ib_hi, 0);

    // run of four zeros, literal 6 right behind
    oc.delete();
    ib_hi = 0;
    send(4'b1011, expand(4'b1011));
    send(4'd6, expand(4'd6));
    idle(3);
    consecutive("run4", 5);
    check("run4_ib", ib_hi, 3);

    // maximal run under alternating back-pressure
    oc.delete();
    base = nz;
    o_b = 1'b1;
    ob_mode = 1;
    send(4'b1111, expand(4'b1111));
    idle(30);
    ob_mode = 0;
    idle(2);
    check("run8_zeros", nz - base, 8);
    check("run8_drain", sb.size(), 0);

    // single-zero run then literal 2
    oc.delete();
    ib_hi = 0;
    send(4'b1000, expand(4'b1000));
    send(4'd2, expand(4'd2));
    idle(3);
    consecutive("run1", 2);
    check("run1_ib", ib_hi, 0);

    // reset on the second zero of a maximal run
    base = nz;
    send(4'b1111, expand(4'b1111));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_o_v", int'(o_v), 0);
    idle(4);
    check("midrst_zeros", nz - base, 2);
    oc.delete();
    send(4'd5, expand(4'd5));
    idle(2);
    check("midrst_next", oc.size(), 1);

    // random encoder loopback
    nd = 300;
    for (int k = 0; k < nd; k++) begin
      if ($urandom_range(0, 1) == 1) data.push_back(3'd0);
      else data.push_back(3'($urandom_range(0, 7)));
    end
    ob_mode = 2;
    i = 0;
    while (i < nd) begin
      chunk.delete();
      if (data[i] != 3'd0 || $urandom_range(0, 7) == 0) begin
        tok = {1'b0, data[i]};
        chunk.push_back(data[i]);
        i++;
      end else begin
        len = 0;
        while (i < nd && data[i] == 3'd0 && len < 8) begin
          chunk.push_back(3'd0);
          len++;
          i++;
        end
        tok = {1'b1, 3'(len - 1)};
      end
      send(tok, chunk);
      idle(int'($urandom_range(0, 2)));
    end
    for (int k = 0; k < 2000 && sb.size() != 0; k++) @(negedge clk);
    check("loop_drain", sb.size(), 0);
    ob_mode = 0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zld_xc.md
ZLD_XC -- requirements
Module: zld_xc

Interface
REQ-001 SHALL have parameter: DW, default 3, width of decoded data; token width is DW+1.
REQ-002 SHALL have port: clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: i_d  input  DW+1  token stream from zero run-length encoder.
REQ-005 SHALL have port: i_v  input  1  i_d valid.
REQ-006 SHALL have port: i_b  output  1  back-pressure to encoder; token accepted only when i_v=1 and i_b=0.
REQ-007 SHALL have port: o_d  output  DW  decoded sample.
REQ-008 SHALL have port: o_v  output  1  o_d valid.
REQ-009 SHALL have port: o_b  input  1  downstream back-pressure; sample consumed only when o_v=1 and o_b=0.

Function
REQ-010 SHALL interpret the token format as follows: i_d[DW]=0 is a literal with value i_d[DW-1:0]; i_d[DW]=1 is a zero run of length i_d[DW-1:0]+1 (1..2^DW).
REQ-011 SHALL hold o_d/o_v in an output register; "slot free" = !o_v | !o_b.
REQ-012 SHALL implement a two-state FSM: S_FETCH and S_RUN, with a DW-bit down-counter cnt holding the zeros still owed after the one presented.
REQ-013 In S_FETCH, SHALL drive i_b = !slot_free; in S_RUN, SHALL drive i_b = 1.
REQ-014 In S_FETCH, on accepting a literal, SHALL load o_d=value and o_v=1 on the next edge and remain in S_FETCH.
REQ-015 In S_FETCH, on accepting a run token t, SHALL load o_d=0 and o_v=1; if t[DW-1:0]=0, SHALL remain in S_FETCH, else SHALL load cnt=t[DW-1:0] and enter S_RUN.
REQ-016 In S_RUN with slot free, SHALL load o_d=0 and o_v=1 and decrement cnt; when cnt=1 at that edge, SHALL return to S_FETCH.
REQ-017 In S_RUN with slot not free, SHALL hold o_d, o_v, cnt and state.
REQ-018 In S_FETCH with slot free and no token accepted, SHALL clear o_v on the next edge.
REQ-019 SHALL have a latency of 1 cycle from token acceptance to first o_v; with o_b=0, throughput is 1 sample per cycle, and a run of L zeros occupies exactly L consecutive output cycles.
REQ-020 SHALL accept a literal of value 0 and emit it as a single 0 sample.
REQ-021 SHALL keep o_d stable while o_v=1 and o_b=1.
REQ-022 SHALL emit a maximal run token (all-ones field) as exactly 2^DW zeros; cnt SHALL never wrap.

Reset
REQ-023 When reset=0 at a rising edge, SHALL force state=S_FETCH, cnt=0, o_v=0, o_d=0, regardless of in-progress run; i_b SHALL be 0 in the cycle after reset deasserts.
REQ-024 Reset asserted mid-run SHALL discard the remaining owed zeros; no partial output after reset.

Structure
REQ-025 SHALL place token-field constants (flag bit position, run-field width) and FSM state encodings in shared package zle_pkg, used by both the encoder and this decoder.
REQ-026 SHALL split the design into zld_xc_fsm (state, cnt, i_b, load enables) and a top-level holding the output datapath register.

Verification
REQ-027 Verification SHALL cover: literals 3,5,7 back-to-back with o_b=0 -> o_d 3,5,7 on consecutive cycles, 1-cycle latency, i_b=0 throughout.
REQ-028 Verification SHALL cover: run token 4'b1011 -> four 0 samples on consecutive cycles, i_b=1 for 3 cycles, next literal 6 follows immediately.
REQ-029 Verification SHALL cover: run token 4'b1111 with o_b toggling 1,0 every cycle -> exactly 8 zeros delivered, o_d stable while o_b=1.
REQ-030 Verification SHALL cover: run token 4'b1000 then literal 2 -> single 0 then 2, state never leaves S_FETCH.
REQ-031 Verification SHALL cover: reset=0 on the 2nd zero of a 4'b1111 run -> o_v=0 next cycle, only 2 zeros ever emitted, next token decoded normally.
REQ-032 Verification SHALL cover: zle_xc -> zld_xc loopback with random 3-bit data and random o_b -> output sequence equals input sequence.
